// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared FSM state type and word-assembly constants for inst_loader
package inst_loader_pkg;

    // Bytes assembled into one instruction or header word.
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// rtl/inst_loader_byte_packer.sv - big-endian byte-to-word packer shared by header and body phases
//
// Ports:
//   CLK, reset     : clock, synchronous active-high reset
//   clear_i        : discard any partial word; a byte presented in the same cycle
//                    becomes byte 0 of a fresh word
//   valid_i/data_i : incoming byte
//   word_o         : assembled word (previous three bytes plus data_i)
//   word_valid_o   : high in the cycle the 4th byte of a word is presented
module byte_packer (
    input  logic        CLK,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    import inst_loader_pkg::*;

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] idx_q, idx_d, idx_eff;
    logic [23:0]           shift_q, shift_d, shift_eff;

    always_comb begin
        idx_eff   = clear_i ? '0 : idx_q;
        shift_eff = clear_i ? '0 : shift_q;
        idx_d     = idx_eff;
        shift_d   = shift_eff;
        if (valid_i) begin
            // Index wraps 3 -> 0 naturally through the 2-bit add.
            idx_d   = idx_eff + 1'b1;
            shift_d = {shift_eff[15:0], data_i};
        end
        word_o       = {shift_eff, data_i};
        word_valid_o = valid_i && (idx_eff == LAST_IDX);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - serial byte stream to instruction-memory word loader
//
// Stream format: 4-byte big-endian word count N, then N big-endian words.
// Optional feature macro: INST_LOADER_TIMEOUT_EN (inter-byte timeout abort).
//
// Ports:
//   CLK, reset        : clock, synchronous active-high reset
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   loader_data       : last instruction word written (held between words)
//   loader_ready      : one-cycle write strobe for loader_data
//   loader_enable     : high for the whole load session
//   load_done         : one-cycle pulse on normal session end
//   overflow          : sticky, header count exceeded memory depth
//   timeout_err       : sticky, session aborted on inter-byte timeout
module inst_loader #(
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] loader_data,
    output logic        loader_ready,
    output logic        loader_enable,
    output logic        load_done,
    output logic        overflow,
    output logic        timeout_err
);
    import inst_loader_pkg::*;

    // Memory depth widened to 33 bits so N up to 2^32-1 compares without wrap.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    state_e      state_q, state_d;
    logic        enable_q, enable_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic [31:0] data_q, data_d;
    logic [31:0] n_q, n_d;
    logic [31:0] wcnt_q, wcnt_d;

    logic        pk_clear, pk_valid, pk_word_valid;
    logic [31:0] pk_word;

`ifdef INST_LOADER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic        tmo_q, tmo_d;
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    byte_packer u_packer (
        .CLK          (CLK),
        .reset        (reset),
        .clear_i      (pk_clear),
        .valid_i      (pk_valid),
        .data_i       (rx_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        data_d   = data_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        pk_clear = 1'b0;
        pk_valid = 1'b0;
`ifdef INST_LOADER_TIMEOUT_EN
        tmo_d    = tmo_q;
        to_cnt_d = '0;
`endif

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    // Session start: this byte is header byte 0 of a clean packer.
                    state_d  = HEADER;
                    enable_d = 1'b1;
                    ovf_d    = 1'b0;
                    n_d      = '0;
                    wcnt_d   = '0;
                    pk_clear = 1'b1;
                    pk_valid = 1'b1;
`ifdef INST_LOADER_TIMEOUT_EN
                    tmo_d    = 1'b0;
`endif
                end
            end
            HEADER: begin
                pk_valid = rx_valid;
                if (pk_word_valid) begin
                    n_d     = pk_word;
                    wcnt_d  = '0;
                    ovf_d   = ({1'b0, pk_word} > DEPTH);
                    state_d = (pk_word == '0) ? FINISH : BODY;
                end
            end
            BODY: begin
                pk_valid = rx_valid;
                if (pk_word_valid) begin
                    // Words beyond memory depth are consumed but never written.
                    if ({1'b0, wcnt_q} < DEPTH) begin
                        data_d  = pk_word;
                        ready_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + 32'd1;
                    if (({1'b0, wcnt_q} + 33'd1) == {1'b0, n_q}) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                // One-cycle tail keeps enable high across the last write strobe.
                state_d  = IDLE;
                enable_d = 1'b0;
                done_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

`ifdef INST_LOADER_TIMEOUT_EN
        if ((state_q == HEADER) || (state_q == BODY)) begin
            if (!rx_valid) begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (to_cnt_q == TO_LAST) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                    tmo_d    = 1'b1;
                    pk_clear = 1'b1;
                    to_cnt_d = '0;
                end
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
`ifdef INST_LOADER_TIMEOUT_EN
            tmo_q    <= 1'b0;
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
`ifdef INST_LOADER_TIMEOUT_EN
            tmo_q    <= tmo_d;
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign loader_data   = data_q;
    assign loader_ready  = ready_q;
    assign loader_enable = enable_q;
    assign load_done     = done_q;
    assign overflow      = ovf_q;

`ifdef INST_LOADER_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_err           = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed scoreboard bench for inst_loader
module tb_inst_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] loader_data;
    logic        loader_ready;
    logic        loader_enable;
    logic        load_done;
    logic        overflow;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    int cyc = 0;
    int ready_cnt = 0;
    int done_cnt = 0;
    int last_ready_cyc = 0;
    int done_cyc = 0;

    always #5 CLK = ~CLK;

    inst_loader #(
        .ADDR_WIDTH     (2),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .loader_data   (loader_data),
        .loader_ready  (loader_ready),
        .loader_enable (loader_enable),
        .load_done     (load_done),
        .overflow      (overflow),
        .timeout_err   (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each write strobe.
    always @(negedge CLK) begin
        cyc++;
        if (loader_ready === 1'b1) begin
            ready_cnt++;
            last_ready_cyc = cyc;
            chk("ready_while_enable", loader_enable, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_ready_qsize", 0, 1);
            end else begin
                chk("loader_data", loader_data, exp_q.pop_front());
            end
        end
        if (load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            chk("enable_low_at_done", loader_enable, 0);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt == base && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, done_cnt - base, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, loader_data, 0);
        chk({tag, "_ready"}, loader_ready, 0);
        chk({tag, "_enable"}, loader_enable, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    initial begin
        int r0, d0;
        logic [31:0] w;

        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge CLK);
        chk("idle_enable", loader_enable, 0);

        // Two-word load with idle gaps between bytes.
        r0 = ready_cnt; d0 = done_cnt;
        exp_q.push_back(32'h0800_0001);
        exp_q.push_back(32'hDEAD_BEEF);
        send(8'h00, 1);
        chk("t1_enable_rise", loader_enable, 1);
        send(8'h00, 1); send(8'h00, 1); send(8'h02, 1);
        send_word(32'h0800_0001, 1);
        send_word(32'hDEAD_BEEF, 1);
        wait_done(d0, "t1_done");
        chk("t1_ready_count", ready_cnt - r0, 2);
        chk("t1_done_after_last_ready", done_cyc - last_ready_cyc, 1);
        chk("t1_enable_low", loader_enable, 0);
        chk("t1_ovf", overflow, 0);
        repeat (2) @(negedge CLK);

        // Empty program.
        r0 = ready_cnt; d0 = done_cnt;
        send(8'h00, 0);
        chk("t2_enable_rise", loader_enable, 1);
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        wait_done(d0, "t2_done");
        chk("t2_ready_count", ready_cnt - r0, 0);
        chk("t2_enable_low", loader_enable, 0);
        repeat (2) @(negedge CLK);

        // N=6 into a 4-word memory: last two words consumed silently.
        r0 = ready_cnt; d0 = done_cnt;
        send_word(32'h0000_0006, 0);
        chk("t3_ovf_at_header", overflow, 1);
        for (int i = 0; i < 6; i++) begin
            w = 32'h1000_0000 + i * 32'h0101_0101;
            if (i < 4) exp_q.push_back(w);
            send_word(w, 0);
        end
        wait_done(d0, "t3_done");
        chk("t3_ready_count", ready_cnt - r0, 4);
        chk("t3_ovf_sticky", overflow, 1);
        repeat (2) @(negedge CLK);

        // N=3 with rx_valid every cycle; overflow clears at session start.
        r0 = ready_cnt; d0 = done_cnt;
        send(8'h00, 0);
        chk("t4_ovf_cleared", overflow, 0);
        send(8'h00, 0); send(8'h00, 0); send(8'h03, 0);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_word(w, 0);
        end
        wait_done(d0, "t4_done");
        chk("t4_ready_count", ready_cnt - r0, 3);
        repeat (2) @(negedge CLK);

        // Reset after 6 body bytes, then a fresh session.
        r0 = ready_cnt; d0 = done_cnt;
        send_word(32'h0000_0002, 0);
        exp_q.push_back(32'h1234_5678);
        send_word(32'h1234_5678, 0);
        send(8'h99, 0); send(8'h88, 0);
        reset = 1'b1;
        @(negedge CLK);
        check_all_zero("t5_after_reset");
        reset = 1'b0;
        @(negedge CLK);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_ready_count", ready_cnt - r0, 1);
        r0 = ready_cnt; d0 = done_cnt;
        exp_q.push_back(32'hCAFE_F00D);
        send_word(32'h0000_0001, 0);
        send_word(32'hCAFE_F00D, 0);
        wait_done(d0, "t5_fresh_done");
        chk("t5_fresh_ready_count", ready_cnt - r0, 1);
        repeat (2) @(negedge CLK);

`ifdef INST_LOADER_TIMEOUT_EN
        // Stall mid-word long enough to trip the 50-cycle timeout.
        d0 = done_cnt;
        send_word(32'h0000_0002, 0);
        send(8'h11, 0); send(8'h22, 0);
        repeat (60) @(negedge CLK);
        chk("t6_timeout_err", timeout_err, 1);
        chk("t6_enable_low", loader_enable, 0);
        chk("t6_no_done", done_cnt - d0, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 2, giving log2 of instruction memory depth in words.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the inter-byte timeout in clock cycles when the timeout feature is compiled in.
REQ-003 The block SHALL have port CLK, input, 1 bit, the system clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits, a received serial byte.
REQ-006 The block SHALL have port rx_valid, input, 1 bit, a one-cycle pulse marking rx_data valid.
REQ-007 The block SHALL have port loader_data, output, 32 bits, the assembled instruction word.
REQ-008 The block SHALL have port loader_ready, output, 1 bit, a one-cycle pulse marking loader_data valid.
REQ-009 The block SHALL have port loader_enable, output, 1 bit, held high for the whole load session.
REQ-010 The block SHALL have port load_done, output, 1 bit, a one-cycle pulse when a session ends normally.
REQ-011 The block SHALL have port overflow, output, 1 bit, a sticky flag set when the header count exceeds 2**ADDR_WIDTH.
REQ-012 The block SHALL have port timeout_err, output, 1 bit, a sticky flag set on inter-byte timeout; it SHALL be tied 0 when the timeout feature is compiled out.

Function
REQ-013 The FSM SHALL have the states IDLE, HEADER, BODY and FINISH.
REQ-014 In IDLE, any rx_valid SHALL move the FSM to HEADER; loader_enable SHALL rise in the next cycle, and that byte SHALL be header byte 0.
REQ-015 Bytes SHALL be packed big-endian: the first byte goes to [31:24], the fourth byte to [7:0].
REQ-016 HEADER SHALL collect 4 bytes into a 32-bit count N, then enter BODY, or FINISH if N==0.
REQ-017 In BODY, each 4th byte SHALL update loader_data and pulse loader_ready for exactly one cycle, in the cycle after that byte's rx_valid.
REQ-018 loader_data SHALL hold its value until the next word.
REQ-019 The first loader_ready SHALL occur at least 4 cycles after loader_enable rises.
REQ-020 This lets the downstream memory leave its fetch state before any write arrives.
REQ-021 After N words, the FSM SHALL enter FINISH.
REQ-022 loader_enable SHALL remain high during the cycle of the last loader_ready pulse.
REQ-023 loader_enable SHALL drop 1 cycle later, with load_done pulsing in that same cycle, and the FSM SHALL return to IDLE.
REQ-024 Words with index ≥ 2**ADDR_WIDTH SHALL be consumed from the byte stream but SHALL NOT produce loader_ready.
REQ-025 In that case, overflow SHALL be set as soon as the header completes.
REQ-026 rx_valid in FINISH SHALL be ignored, and the byte SHALL be dropped.
REQ-027 An internal word counter SHALL be 32 bits wide and SHALL compare against N without wrap.
REQ-028 The 2-bit byte index SHALL wrap from 3 to 0.
REQ-029 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no loss.
REQ-030 loader_ready SHALL never be asserted while loader_enable is low.

Reset
REQ-031 While reset is high, the FSM SHALL go to IDLE.
REQ-032 While reset is high, loader_data SHALL be 0, and loader_ready, loader_enable, load_done, overflow and timeout_err SHALL be 0.
REQ-033 While reset is high, the byte index, word counter and N SHALL be 0.
REQ-034 Reset asserted mid-session SHALL abort the session with no load_done, and partial words SHALL be discarded.
REQ-035 rx_valid coincident with reset SHALL be ignored.
REQ-036 Sticky flags SHALL clear only on reset or at the start of the next session.

Configuration
REQ-037 The timeout feature SHALL be compiled in only when macro INST_LOADER_TIMEOUT_EN is defined.
REQ-038 With INST_LOADER_TIMEOUT_EN defined, a cycle counter SHALL restart on every rx_valid in HEADER or BODY.
REQ-039 With INST_LOADER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set timeout_err, drop loader_enable in the next cycle without load_done, and return the FSM to IDLE.
REQ-040 With INST_LOADER_TIMEOUT_EN undefined, no timeout counter SHALL exist, and a stalled stream SHALL hold the FSM in its state indefinitely.

Structure
REQ-041 Package inst_loader_pkg SHALL hold the FSM state enum and the byte-per-word constant (4).
REQ-042 Sub-module byte_packer SHALL shift bytes into a 32-bit register and pulse word_valid on every 4th byte.
REQ-043 byte_packer SHALL have a clear input used on session start and on abort.
REQ-044 byte_packer SHALL be shared by the HEADER and BODY phases.

Verification
REQ-045 The bench SHALL cover: bytes 00 00 00 02, then 08 00 00 01, then DE AD BE EF -> two loader_ready pulses with data 0x08000001 and 0xDEADBEEF, loader_enable falling 1 cycle after the 2nd pulse, and load_done=1.
REQ-046 The bench SHALL cover: header 00 00 00 00 -> no loader_ready, and enable high for ≥1 cycle then low with load_done.
REQ-047 The bench SHALL cover: ADDR_WIDTH=2 with header N=6 and 24 body bytes -> exactly 4 loader_ready pulses, overflow=1, and load_done=1.
REQ-048 The bench SHALL cover: rx_valid asserted every cycle for a full N=3 session -> 3 pulses with correct data and no dropped bytes.
REQ-049 The bench SHALL cover: reset pulsed after 6 body bytes -> all outputs 0 next cycle, and a fresh session loads correctly.
REQ-050 The bench SHALL cover: with INST_LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=50, stall for 60 cycles after 2 body bytes -> timeout_err=1, loader_enable=0, and no load_done.
